// File: rtl/pwm_pkg.sv
// pwm_pkg: register map, ctrl bit positions and ctrl struct shared by the PWM core
package pwm_pkg;
  localparam logic [4:0] PWM_DVSR_REG = 5'd0;
  localparam logic [4:0] PWM_CTRL_REG = 5'd1;
  localparam logic [4:0] PWM_STAT_REG = 5'd2;
  localparam logic [4:0] PWM_DUTY_BASE = 5'd16;
  localparam int CTRL_EN = 0;
  localparam int CTRL_CENTER = 1;
  localparam int CTRL_SYNC = 2;
  typedef struct packed {
    logic sync_load;
    logic center;
    logic en;
  } pwm_ctrl_t;
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler, W-bit period counter (edge or up/down when PWM_CENTER_ALIGN_EN), boundary pulse
// ports: clk, rst, en, center (requested mode), pre_clr (restart prescaler), dvsr, cnt, boundary (tick where cnt becomes 0)
module pwm_timebase #(
  parameter int W = 10,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             center,
  input  logic             pre_clr,
  input  logic [PRE_W-1:0] dvsr,
  output logic [W-1:0]     cnt,
  output logic             boundary
);
  localparam logic [W-1:0] MAX = '1;
  logic [PRE_W-1:0] pre;
  logic [W-1:0] cnt_nxt;
  logic tick;
  assign tick = en && pre == dvsr;
`ifdef PWM_CENTER_ALIGN_EN
  logic mode, down;
  assign cnt_nxt = (mode && (down || cnt == MAX)) ? cnt - 1'b1 : cnt + 1'b1;
  assign boundary = tick && (mode ? down && cnt == W'(1) : cnt == MAX);
  // the mode only switches between periods so the running period completes unchanged
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      mode <= center;
      down <= 1'b0;
    end else if (tick) begin
      down <= mode && (down ? cnt != W'(1) : cnt == MAX);
      if (boundary) mode <= center;
    end
  end
`else
  logic unused_center;
  assign unused_center = center;
  assign cnt_nxt = cnt + 1'b1;
  assign boundary = tick && cnt == MAX;
`endif
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      pre <= '0;
      cnt <= '0;
    end else begin
      pre <= (pre_clr || tick) ? '0 : pre + 1'b1;
      if (tick) cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/pwm_core_n.sv
// pwm_core_n: CH-channel W-bit PWM MMIO slot with prescaler, double-buffered duties, period counter
// ports: clk, rst, cs/read/write/addr/wr_data/rd_data (MMIO slot), pwm_out (registered pins)
// optional center-aligned counting is built only when PWM_CENTER_ALIGN_EN is defined
module pwm_core_n import pwm_pkg::*; #(
  parameter int CH = 8,
  parameter int W = 10,
  parameter int PRE_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  output logic [CH-1:0] pwm_out
);
`ifdef PWM_CENTER_ALIGN_EN
  localparam logic CENTER_OK = 1'b1;
`else
  localparam logic CENTER_OK = 1'b0;
`endif
  logic wr;
  logic [PRE_W-1:0] dvsr;
  pwm_ctrl_t ctrl;
  logic [15:0] period_cnt;
  logic [W-1:0] cnt;
  logic boundary;
  logic [15:0][W:0] duty_rd;
  logic unused_ok;
  assign wr = cs && write;
  assign unused_ok = ^{read, wr_data};
  always_ff @(posedge clk) begin
    if (rst) begin
      dvsr <= '0;
      ctrl <= '0;
      period_cnt <= '0;
    end else begin
      if (wr && addr == PWM_DVSR_REG) dvsr <= wr_data[PRE_W-1:0];
      if (wr && addr == PWM_CTRL_REG)
        ctrl <= '{sync_load: wr_data[CTRL_SYNC], center: wr_data[CTRL_CENTER] & CENTER_OK, en: wr_data[CTRL_EN]};
      period_cnt <= (wr && addr == PWM_CTRL_REG) ? '0 : period_cnt + 16'(boundary);
    end
  end
  pwm_timebase #(.W(W), .PRE_W(PRE_W)) u_timebase (
    .clk,
    .rst,
    .en(ctrl.en),
    .center(ctrl.center),
    .pre_clr(wr && addr == PWM_DVSR_REG),
    .dvsr,
    .cnt,
    .boundary
  );
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W:0] shadow, active;
    logic q;
    // active samples shadow before this edge's write, so a boundary-clock write waits one period
    always_ff @(posedge clk) begin
      if (rst) begin
        shadow <= '0;
        active <= '0;
        q <= 1'b0;
      end else begin
        if (wr && addr == 5'(PWM_DUTY_BASE + i)) shadow <= wr_data[W:0];
        if (!ctrl.sync_load || boundary) active <= shadow;
        q <= ctrl.en && active > {1'b0, cnt};
      end
    end
    assign pwm_out[i] = q;
    assign duty_rd[i] = shadow;
  end
  if (CH < 16) begin : g_pad
    assign duty_rd[15:CH] = '0;
  end
  assign rd_data = addr == PWM_DVSR_REG ? 32'(dvsr) :
                   addr == PWM_CTRL_REG ? 32'(ctrl) :
                   addr == PWM_STAT_REG ? {period_cnt, 16'(cnt)} :
                   (addr[4] && int'(addr[3:0]) < CH) ? 32'(duty_rd[addr[3:0]]) : '0;
endmodule
